zxbus_master: RTL and testbench

- ZX-bus initiator: turns single-word host requests into Z80-timed memory and IO bus cycles.
- Drives za/zd/ziorq_n/zmreq_n/zrd_n/zwr_n toward the ZXiznet peripheral.
- Samples read data and ziorqge, honours zwait_n, synchronises zint_n into an interrupt flag.
- Used as the host side of FPGA test rigs and bench models for the card.

---
 rtl/zxbus_pkg.sv | 7 +
 rtl/zxbus_tstate_timer.sv | 17 +
 rtl/zxbus_master.sv | 139 +++++++++++++
 tb/tb_zxbus_master.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/zxbus_pkg.sv
// zxbus_pkg: shared state encoding and constants for the ZX-bus initiator
package zxbus_pkg;
    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_e;
    localparam logic CYC_MEM = 1'b0;
    localparam logic CYC_IO = 1'b1;
    localparam logic [7:0] IDLE_DATA = 8'hFF;
endpackage

// File: rtl/zxbus_tstate_timer.sv
// zxbus_tstate_timer: T_DIV prescaler flagging the last clock of each T-state
module zxbus_tstate_timer #(
    parameter int T_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic last_clk
);
    logic [7:0] cnt_q;
    assign last_clk = cnt_q == 8'(T_DIV - 1);
    // Wrapping on last_clk restarts the count on every state entry.
    always_ff @(posedge clk) begin
        if (rst || restart || last_clk) cnt_q <= '0;
        else cnt_q <= cnt_q + 8'd1;
    end
endmodule

// File: rtl/zxbus_master.sv
// zxbus_master: turns host requests into Z80-timed ZX-bus memory and IO cycles
module zxbus_master
    import zxbus_pkg::*;
#(
    parameter int T_DIV = 2,
    parameter int WAIT_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_io,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        claimed,
    output logic [7:0]  rdata,
    output logic [15:0] za,
    output logic [7:0]  zd_o,
    output logic        zd_oe,
    input  logic [7:0]  zd_i,
    output logic        ziorq_n,
    output logic        zmreq_n,
    output logic        zrd_n,
    output logic        zwr_n,
    input  logic        zwait_n,
    input  logic        ziorqge,
    input  logic        zint_n,
    output logic        irq
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    state_e state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic io_q, io_d, we_q, we_d, last, accept, wait_hit, abort, finish, active_d;
    logic busy_q, done_q, timeout_q, claimed_q, zd_oe_q, irq_q, int_s_q;
    logic ziorq_n_q, zmreq_n_q, zrd_n_q, zwr_n_q;
    logic [7:0] rdata_q, zd_o_q;
    logic [15:0] za_q;

    zxbus_tstate_timer #(.T_DIV(T_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (state_q == IDLE),
        .last_clk (last)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d = wcnt_q;
        accept = state_q == IDLE && req;
        io_d = accept ? req_io : io_q;
        we_d = accept ? req_we : we_q;
        wait_hit = last && !zwait_n && (state_q == TW || (state_q == T2 && io_q == CYC_MEM));
        abort = wait_hit && wcnt_q == WW'(WAIT_MAX);
        finish = last && state_q == T3;
        case (state_q)
            IDLE: if (req) begin
                state_d = T1;
                wcnt_d = '0;
            end
            T1: if (last) state_d = T2;
            T2: if (last) state_d = (io_q == CYC_IO || wait_hit) ? TW : T3;
            TW: if (last) state_d = wait_hit ? TW : T3;
            T3: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort takes priority over the extra wait it would otherwise add.
        if (abort) state_d = IDLE;
        else if (wait_hit) wcnt_d = wcnt_q + WW'(1);
        active_d = state_d inside {T2, TW, T3};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q <= '0;
            io_q <= CYC_MEM;
            we_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            timeout_q <= 1'b0;
            claimed_q <= 1'b0;
            rdata_q <= IDLE_DATA;
            za_q <= '0;
            zd_o_q <= '0;
            zd_oe_q <= 1'b0;
            ziorq_n_q <= 1'b1;
            zmreq_n_q <= 1'b1;
            zrd_n_q <= 1'b1;
            zwr_n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q <= wcnt_d;
            io_q <= io_d;
            we_q <= we_d;
            busy_q <= state_d != IDLE;
            done_q <= finish || abort;
            timeout_q <= abort;
            claimed_q <= finish && io_q == CYC_IO && ziorqge;
            if (finish && !we_q) rdata_q <= (io_q == CYC_MEM || ziorqge) ? zd_i : IDLE_DATA;
            if (accept) begin
                za_q <= req_addr;
                zd_o_q <= req_wdata;
            end
            zd_oe_q <= we_d && state_d != IDLE;
            ziorq_n_q <= !(active_d && io_d == CYC_IO);
            zmreq_n_q <= !(active_d && io_d == CYC_MEM);
            zrd_n_q <= !(active_d && !we_d);
            zwr_n_q <= !(active_d && we_d);
        end
    end

    // Two-flop synchroniser; a floating line reads as released.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_s_q <= 1'b1;
            irq_q <= 1'b0;
        end else begin
            int_s_q <= zint_n !== 1'b0;
            irq_q <= !int_s_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign timeout = timeout_q;
    assign claimed = claimed_q;
    assign rdata = rdata_q;
    assign za = za_q;
    assign zd_o = zd_o_q;
    assign zd_oe = zd_oe_q;
    assign ziorq_n = ziorq_n_q;
    assign zmreq_n = zmreq_n_q;
    assign zrd_n = zrd_n_q;
    assign zwr_n = zwr_n_q;
    assign irq = irq_q;
endmodule

// File: tb/tb_zxbus_master.sv
// tb_zxbus_master: vector table plus scoreboard bench for the ZX-bus initiator
module tb_zxbus_master;
    localparam int TD = 2;
    localparam int WM = 4;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, req_io = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0] req_wdata = '0, zd_i = '0;
    logic zwait_n = 1'b1, ziorqge = 1'b0, zint_n = 1'b1;
    logic busy, done, timeout, claimed, zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n, irq;
    logic [7:0] rdata, zd_o;
    logic [15:0] za;

    typedef struct {
        logic io; logic we; logic [15:0] addr; logic [7:0] wdata; logic [7:0] din; logic ge; int waits;
    } vec_t;
    typedef struct {
        int acc; int lat; logic [15:0] addr; logic we; logic [7:0] wdata; logic [7:0] rdata;
        logic claimed; logic timeout; int iorq; int mreq; int rd; int wr; int oe;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int cyc = 0, checks = 0, errors = 0, rel_cyc = -1, last_done = -1;
    int n_iorq = 0, n_mreq = 0, n_rd = 0, n_wr = 0, n_oe = 0;
    logic [7:0] model_rdata = 8'hFF;

    zxbus_master #(.T_DIV(TD), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .req(req), .req_io(req_io), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
        .timeout(timeout), .claimed(claimed), .rdata(rdata), .za(za), .zd_o(zd_o),
        .zd_oe(zd_oe), .zd_i(zd_i), .ziorq_n(ziorq_n), .zmreq_n(zmreq_n), .zrd_n(zrd_n),
        .zwr_n(zwr_n), .zwait_n(zwait_n), .ziorqge(ziorqge), .zint_n(zint_n), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic clr();
        n_iorq = 0; n_mreq = 0; n_rd = 0; n_wr = 0; n_oe = 0;
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (cyc == rel_cyc) zwait_n = 1'b1;
        if (rst) clr();
        else begin
            n_iorq += int'(!ziorq_n); n_mreq += int'(!zmreq_n);
            n_rd += int'(!zrd_n); n_wr += int'(!zwr_n); n_oe += int'(zd_oe);
            if (done) begin
                last_done = cyc;
                if (sb.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("latency", cyc - e.acc, e.lat);
                    chk("timeout", timeout, e.timeout);
                    chk("claimed", claimed, e.claimed);
                    chk("rdata", rdata, e.rdata);
                    chk("za", za, e.addr);
                    chk("iorq_clks", n_iorq, e.iorq);
                    chk("mreq_clks", n_mreq, e.mreq);
                    chk("rd_clks", n_rd, e.rd);
                    chk("wr_clks", n_wr, e.wr);
                    chk("oe_clks", n_oe, e.oe);
                    if (e.we) chk("zd_o", zd_o, e.wdata);
                end
                clr();
            end
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        int w, act;
        bit to;
        req_io = v.io; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        zd_i = v.din; ziorqge = v.ge; req = 1'b1;
        to = v.waits > WM;
        w = to ? WM : v.waits;
        act = (v.io ? 3 : 2) * TD + w * TD - (to ? TD : 0);
        if (!to && !v.we) model_rdata = (!v.io || v.ge) ? v.din : 8'hFF;
        e.acc = cyc; e.addr = v.addr; e.we = v.we; e.wdata = v.wdata; e.timeout = to;
        e.lat = (v.io ? 4 : 3) * TD + 1 + w * TD - (to ? TD : 0);
        e.claimed = !to && v.io && v.ge;
        e.rdata = model_rdata;
        e.iorq = v.io ? act : 0; e.mreq = v.io ? 0 : act;
        e.rd = v.we ? 0 : act; e.wr = v.we ? act : 0; e.oe = v.we ? act + TD : 0;
        if (v.waits > 0) begin
            zwait_n = 1'b0;
            rel_cyc = cyc + (v.io ? 2 : 1) * TD + v.waits * TD + 1;
        end
        sb.push_back(e);
    endtask

    task automatic run(input vec_t v);
        drive(v);
        tick();
        req = 1'b0;
        for (int n = 0; n < 200 && sb.size() != 0; n++) tick();
        if (sb.size() != 0) begin
            chk("done_wait", 0, 1);
            sb.delete();
        end
        zwait_n = 1'b1;
        rel_cyc = -1;
    endtask

    initial begin
        int d1, d2;
        vec_t v;
        vecs[0] = '{1'b1, 1'b1, 16'h00AB, 8'h5A, 8'h00, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 16'h01AB, 8'h00, 8'h3C, 1'b1, 0};
        vecs[2] = '{1'b1, 1'b0, 16'h01AB, 8'h00, 8'h3C, 1'b0, 0};
        vecs[3] = '{1'b0, 1'b0, 16'h2000, 8'h00, 8'hC9, 1'b0, 0};
        vecs[4] = '{1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 16'h00FE, 8'h00, 8'h77, 1'b1, 3};
        vecs[6] = '{1'b0, 1'b0, 16'h4000, 8'h00, 8'h11, 1'b0, 2};
        vecs[7] = '{1'b1, 1'b0, 16'h00FD, 8'h00, 8'h66, 1'b1, 99};
        vecs[8] = '{1'b0, 1'b1, 16'h8001, 8'h3E, 8'h00, 1'b0, 99};
        repeat (3) tick();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_timeout", timeout, 0);
        chk("rst_claimed", claimed, 0); chk("rst_rdata", rdata, 8'hFF); chk("rst_za", za, 0);
        chk("rst_zd_o", zd_o, 0); chk("rst_zd_oe", zd_oe, 0); chk("rst_iorq", ziorq_n, 1);
        chk("rst_mreq", zmreq_n, 1); chk("rst_rd", zrd_n, 1); chk("rst_wr", zwr_n, 1);
        chk("rst_irq", irq, 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) run(vecs[i]);

        // Reset landing in T2 of an IO write.
        v = '{1'b1, 1'b1, 16'h0055, 8'h99, 8'h00, 1'b0, 0};
        req_io = v.io; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req = 1'b1;
        tick();
        req = 1'b0;
        tick(); tick();
        chk("mid_iorq_low", ziorq_n, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_iorq", ziorq_n, 1); chk("mid_rst_wr", zwr_n, 1); chk("mid_rst_mreq", zmreq_n, 1);
        chk("mid_rst_rd", zrd_n, 1); chk("mid_rst_oe", zd_oe, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        repeat (12) tick();
        chk("post_rst_busy", busy, 0);
        run('{1'b0, 1'b0, 16'h3003, 8'h00, 8'h5D, 1'b0, 0});

        // Back-to-back IO reads with req held high.
        last_done = -1;
        drive('{1'b1, 1'b0, 16'h0300, 8'h00, 8'h42, 1'b1, 0});
        for (int n = 0; n < 100 && last_done < 0; n++) tick();
        d1 = last_done;
        drive('{1'b1, 1'b0, 16'h0301, 8'h00, 8'h24, 1'b1, 0});
        last_done = -1;
        for (int n = 0; n < 100 && last_done < 0; n++) tick();
        d2 = last_done;
        req = 1'b0;
        chk("b2b_gap", d2 - d1, 4 * TD + 1);
        repeat (3) tick();
        chk("b2b_idle", busy, 0);
        chk("b2b_sb_empty", sb.size(), 0);
        sb.delete();

        // Five-clock interrupt pulse.
        for (int i = 0; i < 10; i++) begin
            chk("irq", irq, (i >= 2 && i <= 6) ? 1 : 0);
            if (i == 0) zint_n = 1'b0;
            if (i == 5) zint_n = 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
